module_fmap_collect: RTL and testbench

Collects the pooled 8-bit signed pixel stream that a conv layer emits on `valid_out`/`dout` into an on-chip frame buffer. Once a complete output map is stored, it replays the map in raster order through a valid/ready stream, so the next layer or the host read-back path can pull it. It sits directly downstream of the conv/quant/ReLU/max-pool chain and is the receiving end of that layer's output stream.

---
 rtl/module_fmap_collect.sv | 129 ++++++++++++
 tb/tb_module_fmap_collect.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/module_fmap_collect.sv
// Frame collector for a pooled conv-layer output map.
// Stores one IMG_W x IMG_H map of 8-bit signed pixels in arrival order, then
// replays it in raster order over a valid/ready stream once a read is requested.
module module_fmap_collect #(
  parameter int IMG_W = 14,
  parameter int IMG_H = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic signed [7:0] din,
  input  logic              rd_start,
  input  logic              rd_ready,
  output logic              valid_out,
  output logic signed [7:0] dout,
  output logic              last_out,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow
);

  localparam int DATA_W = 8;
  localparam int N      = IMG_W * IMG_H;
  // A single-pixel map still needs a one-bit pointer to stay legal.
  localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic signed [DATA_W-1:0] mem [N];

  logic [1:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [PTR_W-1:0] wr_addr;
  logic             wr_en;
  logic             hs;

  // Writes are only accepted while the map is still being collected.
  assign wr_en      = valid_in & ((state == S_IDLE) | (state == S_FILL));
  // The first pixel of a frame always lands at address 0, whatever wr_ptr holds.
  assign wr_addr    = (state == S_FILL) ? wr_ptr : '0;
  assign hs         = valid_out & rd_ready;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  // Frame buffer: plain storage, deliberately without reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
  end

  // Fill/drain sequencing, output register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_out  <= 1'b0;
      dout       <= '0;
      last_out   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            busy <= 1'b1;
            if (N == 1) begin
              state      <= S_FULL;
              frame_done <= 1'b1;
            end else begin
              wr_ptr <= PTR_W'(1);
              state  <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (valid_in) begin
            if (wr_ptr == LAST_PTR) begin
              wr_ptr     <= '0;
              state      <= S_FULL;
              frame_done <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end
        end
        S_FULL: begin
          if (valid_in) begin
            overflow <= 1'b1;
          end
          if (rd_start) begin
            state     <= S_DRAIN;
            dout      <= mem[0];
            valid_out <= 1'b1;
            last_out  <= (N == 1);
          end
        end
        default: begin
          if (valid_in) begin
            overflow <= 1'b1;
          end
          if (hs) begin
            if (last_out) begin
              valid_out <= 1'b0;
              last_out  <= 1'b0;
              rd_ptr    <= '0;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end else begin
              // Prefetch the next pixel so a held-high ready streams without bubbles.
              rd_ptr   <= rd_ptr_inc;
              dout     <= mem[rd_ptr_inc];
              last_out <= (rd_ptr_inc == LAST_PTR);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_fmap_collect.sv
// Directed bench for module_fmap_collect with a 4x2 map (8 pixels).
module tb_module_fmap_collect;

  logic              clk;
  logic              rst_n;
  logic              valid_in;
  logic signed [7:0] din;
  logic              rd_start;
  logic              rd_ready;
  logic              valid_out;
  logic signed [7:0] dout;
  logic              last_out;
  logic              frame_done;
  logic              busy;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  module_fmap_collect #(.IMG_W(4), .IMG_H(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .din       (din),
    .rd_start  (rd_start),
    .rd_ready  (rd_ready),
    .valid_out (valid_out),
    .dout      (dout),
    .last_out  (last_out),
    .frame_done(frame_done),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write 8 pixels base..base+7, with 'gap' idle cycles after each write.
  task automatic fill(input int base, input int gap, input bit start_on_last);
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1;
      din      = 8'(base + i);
      rd_start = start_on_last && (i == 7);
      tick();
      valid_in = 1'b0;
      rd_start = 1'b0;
      check("frame_done", int'(frame_done), (i == 7) ? 1 : 0);
      check("busy_fill", int'(busy), 1);
      for (int g = 0; g < gap; g++) begin
        tick();
        check("frame_done_gap", int'(frame_done), 0);
      end
    end
  endtask

  task automatic start_read(input int base);
    check("vld_before_start", int'(valid_out), 0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("vld_after_start", int'(valid_out), 1);
    check("dout_first", int'(dout), base);
  endtask

  // Drain the map with a ready pattern (bit c for cycle c, 1 after pat_len).
  task automatic drain(input int base, input int pat_len, input logic [15:0] pat,
                       output int cycles);
    int idx;
    bit stalled;
    logic signed [7:0] held;
    idx = 0;
    cycles = 0;
    while (idx < 8 && cycles < 64) begin
      rd_ready = (cycles < pat_len) ? pat[cycles] : 1'b1;
      if (!valid_out) begin
        check("drain_vld", int'(valid_out), 1);
      end
      if (valid_out && rd_ready) begin
        check("drain_dout", int'(dout), base + idx);
        check("drain_last", int'(last_out), (idx == 7) ? 1 : 0);
        idx++;
      end
      stalled = valid_out && !rd_ready;
      held    = dout;
      tick();
      cycles++;
      if (stalled) begin
        check("hold_dout", int'(dout), int'(held));
        check("hold_vld", int'(valid_out), 1);
      end
    end
    check("drain_count", idx, 8);
    check("vld_after_drain", int'(valid_out), 0);
    check("last_after_drain", int'(last_out), 0);
    check("busy_after_drain", int'(busy), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    din      = '0;
    rd_start = 1'b0;
    rd_ready = 1'b0;

    // Reset and idle behaviour
    repeat (3) tick();
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_last_out", int'(last_out), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("idle_start_vld", int'(valid_out), 0);
      check("idle_busy", int'(busy), 0);
      tick();
    end

    // Basic fill and drain, -8..-1
    fill(-8, 0, 1'b0);
    tick();
    check("frame_done_pulse_end", int'(frame_done), 0);
    check("busy_full", int'(busy), 1);
    start_read(-8);
    drain(-8, 0, 16'h0000, cyc);
    check("drain_cycles", cyc, 8);

    // Backpressure during drain
    fill(30, 0, 1'b0);
    start_read(30);
    drain(30, 10, 16'h03E9, cyc);
    check("bp_cycles", cyc, 11);

    // Overflow on a full map
    fill(1, 0, 1'b0);
    check("ovf_before", int'(overflow), 0);
    valid_in = 1'b1;
    din      = 8'sh55;
    tick();
    valid_in = 1'b0;
    check("ovf_set", int'(overflow), 1);
    start_read(1);
    drain(1, 0, 16'h0000, cyc);
    check("ovf_sticky", int'(overflow), 1);

    // Gapped input with rd_start coincident with the last write
    fill(10, 1, 1'b1);
    check("corner_vld0", int'(valid_out), 0);
    tick();
    check("corner_vld1", int'(valid_out), 0);
    check("corner_busy", int'(busy), 1);
    start_read(10);
    drain(10, 0, 16'h0000, cyc);

    // Reset mid-drain, then a fresh frame
    fill(40, 0, 1'b0);
    start_read(40);
    rd_ready = 1'b1;
    repeat (3) tick();
    rd_ready = 1'b0;
    check("mid_dout", int'(dout), 43);
    check("mid_vld", int'(valid_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_vld_drop", int'(valid_out), 0);
    check("async_busy", int'(busy), 0);
    check("async_ovf", int'(overflow), 0);
    check("async_dout", int'(dout), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    fill(32, 0, 1'b0);
    start_read(32);
    drain(32, 0, 16'h0000, cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
